// File: rtl/mem_arbiter.sv
// Two-port line-transfer arbiter: I-cache and D-cache share one memory port.
// Define ARB_ROUND_ROBIN_EN for alternating tie resolution; otherwise D wins ties.
module mem_arbiter #(
  parameter int MEM_LATENCY = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req,
  input  logic [15:0] i_addr,
  output logic [63:0] i_rdata,
  output logic        i_done,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [15:0] d_addr,
  input  logic [63:0] d_wdata,
  output logic [63:0] d_rdata,
  output logic        d_done,
  output logic        m_read,
  output logic        m_write,
  output logic [15:0] m_addr,
  output logic [63:0] m_wdata,
  input  logic [63:0] m_rdata,
  output logic [15:0] i_grant_cnt,
  output logic [15:0] d_grant_cnt
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic [3:0] LAT_M1 = 4'(MEM_LATENCY - 1);

  state_t      stateReg, stateNext;
  logic [3:0]  cntReg, cntNext;
  logic        grantDReg, grantDNext;
  logic        weReg, weNext;
  logic [15:0] addrReg, addrNext;
  logic [63:0] wdataReg, wdataNext;
  logic [63:0] iRdataReg, iRdataNext;
  logic [63:0] dRdataReg, dRdataNext;
  logic [15:0] iGrantCntReg, iGrantCntNext;
  logic [15:0] dGrantCntReg, dGrantCntNext;
  logic        pickD;

`ifdef ARB_ROUND_ROBIN_EN
  logic lastGrantDReg, lastGrantDNext;

  // Tie goes to whoever was not served last; reset value means "I was last".
  always_comb pickD = d_req && (!i_req || !lastGrantDReg);

  always_ff @(posedge clk) begin
    if (reset) lastGrantDReg <= 1'b0;
    else       lastGrantDReg <= lastGrantDNext;
  end
`else
  always_comb pickD = d_req;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      stateReg     <= IDLE;
      cntReg       <= '0;
      grantDReg    <= 1'b0;
      weReg        <= 1'b0;
      addrReg      <= '0;
      wdataReg     <= '0;
      iRdataReg    <= '0;
      dRdataReg    <= '0;
      iGrantCntReg <= '0;
      dGrantCntReg <= '0;
    end else begin
      stateReg     <= stateNext;
      cntReg       <= cntNext;
      grantDReg    <= grantDNext;
      weReg        <= weNext;
      addrReg      <= addrNext;
      wdataReg     <= wdataNext;
      iRdataReg    <= iRdataNext;
      dRdataReg    <= dRdataNext;
      iGrantCntReg <= iGrantCntNext;
      dGrantCntReg <= dGrantCntNext;
    end
  end

  always_comb begin
    stateNext     = stateReg;
    cntNext       = cntReg;
    grantDNext    = grantDReg;
    weNext        = weReg;
    addrNext      = addrReg;
    wdataNext     = wdataReg;
    iRdataNext    = iRdataReg;
    dRdataNext    = dRdataReg;
    iGrantCntNext = iGrantCntReg;
    dGrantCntNext = dGrantCntReg;
`ifdef ARB_ROUND_ROBIN_EN
    lastGrantDNext = lastGrantDReg;
`endif
    case (stateReg)
      IDLE: begin
        if (i_req || d_req) begin
          stateNext  = BUSY;
          cntNext    = LAT_M1;
          grantDNext = pickD;
`ifdef ARB_ROUND_ROBIN_EN
          lastGrantDNext = pickD;
`endif
          if (pickD) begin
            addrNext      = d_addr;
            weNext        = d_we;
            wdataNext     = d_wdata;
            dGrantCntNext = dGrantCntReg + 16'd1;
          end else begin
            addrNext      = i_addr;
            weNext        = 1'b0;
            wdataNext     = '0;
            iGrantCntNext = iGrantCntReg + 16'd1;
          end
        end
      end
      BUSY: begin
        cntNext = cntReg - 4'd1;
        if (cntReg == 4'd0) begin
          stateNext = DONE;
          // Writebacks must not disturb the last line read by D.
          if (!weReg) begin
            if (grantDReg) dRdataNext = m_rdata;
            else           iRdataNext = m_rdata;
          end
        end
      end
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  logic busy;
  assign busy        = (stateReg == BUSY);
  assign m_read      = busy && !weReg;
  assign m_write     = busy && weReg;
  assign m_addr      = busy ? addrReg : 16'd0;
  assign m_wdata     = (busy && weReg) ? wdataReg : 64'd0;
  assign i_done      = (stateReg == DONE) && !grantDReg;
  assign d_done      = (stateReg == DONE) && grantDReg;
  assign i_rdata     = iRdataReg;
  assign d_rdata     = dRdataReg;
  assign i_grant_cnt = iGrantCntReg;
  assign d_grant_cnt = dGrantCntReg;

endmodule
